multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Multicycle successor to the single-cycle RISC-V main decoder. It sequences each instruction through a registered FSM (fetch, decode, execute, memory, writeback). It drives datapath mux selects and enables per state, and handshakes with a variable-latency memory that has a bounded wait. It also keeps a retired-instruction counter. It sits between the instruction register/ALU flags and the multicycle datapath; `Op` comes from the instruction register.

## Interface
- `TIMEOUT`, default 15: max wait cycles for `mem_ready` per access; 0 disables the timeout.
- `CNT_W`, default 32: width of `instret`.
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `Op`  in  7: opcode from the instruction register.
- `Zero`  in  1: ALU zero flag.
- `mem_ready`  in  1: memory completes the current access this cycle.
- `mem_req`  out  1: memory access pending.
- `PCWrite`, `IRWrite`, `MemWrite`, `RegWrite`, `AdrSrc`  out  1 each: datapath enables/select.
- `ALUSrcA`, `ALUSrcB`, `ALUOp`, `ResultSrc`, `ImmSrc`  out  2 each: datapath selects.
- `bus_err`  out  1: one-cycle pulse on memory timeout.
- `trap`  out  1: sticky trap flag (see Configuration).
- `state`  out  4: current FSM state, for debug.
- `instret`  out  `CNT_W`: retired-instruction count.

## Operation
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10, TRAP=11.
- Per-state outputs (unlisted outputs are 0):
  - FETCH: `mem_req`=1, `ALUSrcB`=10, `ResultSrc`=10; `IRWrite`=1 and PCUpdate=1 only in the `mem_ready` cycle.
  - DECODE: `ALUSrcA`=01, `ALUSrcB`=01.
  - MEMADR: `ALUSrcA`=10, `ALUSrcB`=01.
  - MEMREAD: `mem_req`=1, `AdrSrc`=1.
  - MEMWB: `ResultSrc`=01, `RegWrite`=1.
  - MEMWRITE: `mem_req`=1, `AdrSrc`=1, `MemWrite`=1 for the whole state.
  - EXECR: `ALUSrcA`=10, `ALUOp`=10.
  - EXECI: `ALUSrcA`=10, `ALUSrcB`=01, `ALUOp`=10.
  - ALUWB: `RegWrite`=1.
  - BEQ: `ALUSrcA`=10, `ALUOp`=01, Branch=1.
  - JAL: `ALUSrcA`=01, `ALUSrcB`=10, PCUpdate=1.
- `PCWrite` = PCUpdate | (Branch & `Zero`).
- `ImmSrc` is combinational from `Op`: load/I-type 00, store 01, beq 10, jal 11, anything else 00.
- Transitions:
  - FETCH → DECODE on `mem_ready`.
  - DECODE dispatches on `Op`:
    - 0000011 or 0100011 → MEMADR.
    - 0110011 → EXECR.
    - 0010011 → EXECI.
    - 1100011 → BEQ.
    - 1101111 → JAL.
    - Any other opcode is illegal (see Configuration).
  - MEMADR → MEMREAD if `Op`=0000011, else MEMWRITE.
  - MEMREAD → MEMWB on `mem_ready`.
  - MEMWRITE → FETCH on `mem_ready`.
  - EXECR, EXECI, JAL → ALUWB.
  - MEMWB, ALUWB, BEQ → FETCH.
- Wait counter: cleared on entry to FETCH, MEMREAD or MEMWRITE; increments each cycle the FSM holds there without `mem_ready`.
- Timeout: if `TIMEOUT`≠0 and the counter equals `TIMEOUT` with `mem_ready` still low:
  - `bus_err` pulses for one cycle and the FSM moves to FETCH.
  - The abandoned access does not count as retired.
  - `mem_ready` in the same cycle takes priority; that is not a timeout.
- `instret` increments by 1 on the transition out of MEMWB, ALUWB, BEQ, or MEMWRITE (when `mem_ready`). It wraps from all-ones to 0.

## Timing
- Reset (`rst_n`=0, asynchronous): `state`=FETCH, wait counter=0, `instret`=0, `trap`=0, `bus_err`=0.
  - All other outputs take their FETCH values with `mem_ready`=0: `mem_req`=1, `ALUSrcB`=10, `ResultSrc`=10, rest 0.
- Reset mid-instruction aborts it immediately. Nothing retires and no enable is asserted after `rst_n` falls.
- Outputs are Moore on `state`, except `IRWrite`/`PCWrite` (qualified by `mem_ready`/`Zero`) and `ImmSrc`.
- Latency with zero-wait memory:
  - R, I, beq, jal: 4 cycles (beq is 3: FETCH, DECODE, BEQ).
  - sw: 4 cycles.
  - lw: 5 cycles.
- Each memory wait cycle adds 1 cycle.

## Configuration
- `ILLEGAL_OP_TRAP_EN` defined:
  - An illegal opcode in DECODE → TRAP.
  - In TRAP: `trap`=1, all enables 0, `mem_req`=0.
  - TRAP is held until reset, and `instret` does not increment.
- `ILLEGAL_OP_TRAP_EN` undefined:
  - An illegal opcode in DECODE → FETCH, executing as a NOP (the PC was already advanced in FETCH).
  - It is not counted in `instret`.
  - `trap` is tied to 0 and TRAP is unreachable.

## Test plan
- Zero-wait sequence lw, sw, R, beq, I, jal with `mem_ready`=1 throughout:
  - State traces are 0-1-2-3-4, 0-1-2-5, 0-1-6-8, 0-1-9, 0-1-7-8, 0-1-10-8.
  - `instret`=6 at the end.
- beq with `Zero`=1 → `PCWrite`=1 in the BEQ state; with `Zero`=0 → `PCWrite`=0.
- FETCH with `mem_ready` low for 3 cycles, then high:
  - FSM holds in state 0 for 4 cycles.
  - `IRWrite`=1 only in the 4th cycle.
- `TIMEOUT`=4 and `mem_ready` never asserted in MEMREAD:
  - `bus_err` pulses once, 4 cycles after entry.
  - Next state is FETCH; `instret` unchanged.
- `Op`=1111111:
  - With macro: `state`=11 and `trap`=1 until reset.
  - Without macro: back to FETCH and `instret` unchanged.
- `rst_n` pulled low asynchronously mid-MEMWRITE → `MemWrite`=0 and `state`=0 before the next clock edge.
- `CNT_W`=4 → `instret` wraps 15 → 0 on the 16th retirement.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath/memory bundle for multicycle_controller.
// The master side is the controller; the slave side is the datapath, memory and debug observer.
interface multicycle_controller_if #(
  parameter int CNT_W = 32
) ();
  logic [6:0]       Op;
  logic             Zero;
  logic             mem_ready;
  logic             mem_req;
  logic             PCWrite;
  logic             IRWrite;
  logic             MemWrite;
  logic             RegWrite;
  logic             AdrSrc;
  logic [1:0]       ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ALUOp;
  logic [1:0]       ResultSrc;
  logic [1:0]       ImmSrc;
  logic             bus_err;
  logic             trap;
  logic [3:0]       state;
  logic [CNT_W-1:0] instret;

  modport master (
    input  Op, Zero, mem_ready,
    output mem_req, PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc,
           ALUSrcA, ALUSrcB, ALUOp, ResultSrc, ImmSrc,
           bus_err, trap, state, instret
  );

  modport slave (
    output Op, Zero, mem_ready,
    input  mem_req, PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc,
           ALUSrcA, ALUSrcB, ALUOp, ResultSrc, ImmSrc,
           bus_err, trap, state, instret
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM with bounded-wait memory handshake and retired-instruction counter.
// Define ILLEGAL_OP_TRAP_EN to make illegal opcodes park the FSM in a sticky TRAP state.
module multicycle_controller #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  multicycle_controller_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam int                WAIT_W     = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT);

`ifdef ILLEGAL_OP_TRAP_EN
  localparam state_t ILLEGAL_NEXT = S_TRAP;
`else
  localparam state_t ILLEGAL_NEXT = S_FETCH;
`endif

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  instret_q, instret_d;

  logic mem_state;
  logic timeout;
  logic retire;

  logic       mem_req, adr_src, mem_write, reg_write, ir_write;
  logic       pc_update, branch;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src, imm_src;

  assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
  // A same-cycle mem_ready always wins over the timeout.
  assign timeout   = (TIMEOUT != 0) && mem_state && !bus.mem_ready && (wait_q == WAIT_LIMIT);

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH:    if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = ILLEGAL_NEXT;
        endcase
      end
      S_MEMADR:   state_d = (bus.Op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (bus.mem_ready) state_d = S_MEMWB;
      S_MEMWRITE: begin
        if (bus.mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXECR, S_EXECI, S_JAL: state_d = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BEQ: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase

    if (timeout) state_d = S_FETCH;
  end

  // The wait counter restarts whenever a (possibly re-entered) state begins.
  always_comb begin
    wait_d = wait_q;
    if ((state_d != state_q) || timeout) begin
      wait_d = '0;
    end else if (mem_state && !bus.mem_ready) begin
      wait_d = wait_q + WAIT_W'(1);
    end
  end

  assign instret_d = retire ? (instret_q + CNT_W'(1)) : instret_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    mem_req    = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    ir_write   = 1'b0;
    pc_update  = 1'b0;
    branch     = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    result_src = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        // Gated by rst_n so no enable fires while reset is held.
        ir_write   = bus.mem_ready & rst_n;
        pc_update  = bus.mem_ready & rst_n;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      S_ALUWB:    reg_write = 1'b1;
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (bus.Op)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  assign bus.mem_req   = mem_req;
  assign bus.AdrSrc    = adr_src;
  assign bus.MemWrite  = mem_write;
  assign bus.RegWrite  = reg_write;
  assign bus.IRWrite   = ir_write;
  assign bus.PCWrite   = pc_update | (branch & bus.Zero);
  assign bus.ALUSrcA   = alu_src_a;
  assign bus.ALUSrcB   = alu_src_b;
  assign bus.ALUOp     = alu_op;
  assign bus.ResultSrc = result_src;
  assign bus.ImmSrc    = imm_src;
  assign bus.bus_err   = timeout & rst_n;
  assign bus.state     = state_q;
  assign bus.instret   = instret_q;

`ifdef ILLEGAL_OP_TRAP_EN
  assign bus.trap = (state_q == S_TRAP);
`else
  assign bus.trap = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: instruction-path model plus directed literal checks.
// Runs with TIMEOUT=4 and CNT_W=4 so the timeout and counter wrap are reachable quickly.
`timescale 1ns/1ps
module tb_multicycle_controller;

  localparam int TB_TIMEOUT = 4;
  localparam int TB_CNT_W   = 4;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  multicycle_controller_if #(.CNT_W(TB_CNT_W)) bus ();

  multicycle_controller #(.TIMEOUT(TB_TIMEOUT), .CNT_W(TB_CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each opcode expands to the list of states it visits after DECODE; finishing the list retires it.
  function automatic logic [19:0] path_of(input logic [6:0] op);
    case (op)
      OP_LW:   return {4'd3, 4'h2, 4'h3, 4'h4, 4'h0};
      OP_SW:   return {4'd2, 4'h2, 4'h5, 4'h0, 4'h0};
      OP_R:    return {4'd2, 4'h6, 4'h8, 4'h0, 4'h0};
      OP_I:    return {4'd2, 4'h7, 4'h8, 4'h0, 4'h0};
      OP_BEQ:  return {4'd1, 4'h9, 4'h0, 4'h0, 4'h0};
      OP_JAL:  return {4'd2, 4'hA, 4'h8, 4'h0, 4'h0};
      default: return 20'h0;
    endcase
  endfunction

  function automatic logic [3:0] nib(input logic [15:0] p, input int i);
    return p[15-4*i -: 4];
  endfunction

  function automatic bit is_mem(input logic [3:0] s);
    return (s == 4'd0) || (s == 4'd3) || (s == 4'd5);
  endfunction

  function automatic logic [1:0] imm_of(input logic [6:0] op);
    case (op)
      OP_SW:   return 2'b01;
      OP_BEQ:  return 2'b10;
      OP_JAL:  return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  logic [3:0]          m_state;
  logic [15:0]         m_path;
  int                  m_len, m_idx, m_wait;
  logic [TB_CNT_W-1:0] m_instret;
  logic [19:0]         op_path;
  assign op_path = path_of(bus.Op);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state   <= 4'd0;
      m_path    <= 16'h0;
      m_len     <= 0;
      m_idx     <= 0;
      m_wait    <= 0;
      m_instret <= '0;
    end else if (is_mem(m_state) && !bus.mem_ready) begin
      if (m_wait == TB_TIMEOUT) begin
        m_state <= 4'd0;
        m_wait  <= 0;
      end else begin
        m_wait <= m_wait + 1;
      end
    end else begin
      m_wait <= 0;
      if (m_state == 4'd0) begin
        m_state <= 4'd1;
      end else if (m_state == 4'd1) begin
        if (op_path[19:16] == 4'd0) begin
`ifdef ILLEGAL_OP_TRAP_EN
          m_state <= 4'd11;
`else
          m_state <= 4'd0;
`endif
        end else begin
          m_path  <= op_path[15:0];
          m_len   <= int'(op_path[19:16]);
          m_idx   <= 0;
          m_state <= op_path[15:12];
        end
      end else if (m_state == 4'd11) begin
        m_state <= 4'd11;
      end else if (m_idx + 1 < m_len) begin
        m_idx   <= m_idx + 1;
        m_state <= nib(m_path, m_idx + 1);
      end else begin
        m_state   <= 4'd0;
        m_instret <= m_instret + 1'b1;
      end
    end
  end

  // Per-state outputs: {mem_req, AdrSrc, MemWrite, RegWrite, ALUSrcA, ALUSrcB, ALUOp, ResultSrc, PCUpdate, Branch}
  logic [13:0] out_tbl [0:11];
  initial begin
    out_tbl[0]  = 14'b1_0_0_0_00_10_00_10_0_0;
    out_tbl[1]  = 14'b0_0_0_0_01_01_00_00_0_0;
    out_tbl[2]  = 14'b0_0_0_0_10_01_00_00_0_0;
    out_tbl[3]  = 14'b1_1_0_0_00_00_00_00_0_0;
    out_tbl[4]  = 14'b0_0_0_1_00_00_00_01_0_0;
    out_tbl[5]  = 14'b1_1_1_0_00_00_00_00_0_0;
    out_tbl[6]  = 14'b0_0_0_0_10_00_10_00_0_0;
    out_tbl[7]  = 14'b0_0_0_0_10_01_10_00_0_0;
    out_tbl[8]  = 14'b0_0_0_1_00_00_00_00_0_0;
    out_tbl[9]  = 14'b0_0_0_0_10_00_01_00_0_1;
    out_tbl[10] = 14'b0_0_0_0_01_10_00_00_1_0;
    out_tbl[11] = 14'b0_0_0_0_00_00_00_00_0_0;
  end

  bit chk_en = 0;

  task automatic compare_cycle();
    logic [13:0] row;
    logic        exp_rdy, exp_berr;
    row      = out_tbl[m_state];
    exp_rdy  = (m_state == 4'd0) && bus.mem_ready && rst_n;
    exp_berr = rst_n && is_mem(m_state) && !bus.mem_ready && (m_wait == TB_TIMEOUT);
    chk("state", bus.state, m_state);
    chk("sels", {bus.mem_req, bus.AdrSrc, bus.MemWrite, bus.RegWrite,
                 bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.ResultSrc}, row[13:2]);
    chk("IRWrite", bus.IRWrite, exp_rdy);
    chk("PCWrite", bus.PCWrite, row[1] | exp_rdy | (row[0] & bus.Zero));
    chk("ImmSrc", bus.ImmSrc, imm_of(bus.Op));
    chk("bus_err", bus.bus_err, exp_berr);
    chk("trap", bus.trap, m_state == 4'd11);
    chk("instret", bus.instret, m_instret);
  endtask

  always @(negedge clk) if (chk_en) compare_cycle();

  // ---------------- event monitor for directed checks ----------------
  int   cyc = 0, fetch_cyc = 0, irw_cnt = 0, irw_at = 0;
  int   berr_cnt = 0, berr_cyc = 0, rd_entry = 0;
  logic beq_pcw = 1'b0;
  logic [3:0] prev_mon = 4'hF;

  task automatic mon();
    if (bus.state == 4'd0) fetch_cyc++;
    if (bus.IRWrite) begin
      irw_cnt++;
      irw_at = fetch_cyc;
    end
    if (bus.state == 4'd9) beq_pcw = bus.PCWrite;
    if (bus.state == 4'd3 && prev_mon != 4'd3) rd_entry = cyc;
    if (bus.bus_err) begin
      berr_cnt++;
      berr_cyc = cyc;
    end
    prev_mon = bus.state;
    cyc++;
  endtask

  always @(negedge clk) mon();

  // ---------------- stimulus ----------------
  task automatic do_reset();
    rst_n         = 1'b0;
    bus.mem_ready = 1'b0;
    bus.Op        = 7'h0;
    bus.Zero      = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Runs one instruction from FETCH; mem_ready is held low for fwait/mwait cycles in each memory state.
  task automatic run_instr(input logic [6:0] op, input logic z, input int fwait, input int mwait,
                           output logic [31:0] trace, output int cycles);
    int w, prev, st;
    bit done;
    trace  = 32'h0;
    cycles = 0;
    w      = 0;
    prev   = -1;
    done   = 0;
    bus.Op   = op;
    bus.Zero = z;
    while (!done) begin
      st = int'(bus.state);
      if (st != prev) begin
        trace = {trace[27:0], bus.state};
        w     = 0;
      end
      bus.mem_ready = (w >= ((st == 0) ? fwait : mwait));
      w++;
      prev = st;
      @(posedge clk);
      #1;
      cycles++;
      if ((bus.state == 4'd0 && st != 0) || bus.state == 4'd11) done = 1;
      if (cycles > 64) begin
        checks++;
        failures++;
        $display("FAIL instr_bound: op=%b still busy after %0d cycles, required completion", op, cycles);
        done = 1;
      end
    end
    $display("instr op=%b zero=%0b trace=%0h cycles=%0d instret=%0d", op, z, trace, cycles, bus.instret);
  endtask

  logic [31:0] tr;
  int          ncyc;

  initial begin
    bus.Op        = 7'h0;
    bus.Zero      = 1'b0;
    bus.mem_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1 chk_en = 1;
    #1;
    // Reset values, with mem_ready high to confirm enables stay off during reset.
    chk("rst_state", bus.state, 4'd0);
    chk("rst_mem_req", bus.mem_req, 1'b1);
    chk("rst_ALUSrcB", bus.ALUSrcB, 2'b10);
    chk("rst_ResultSrc", bus.ResultSrc, 2'b10);
    chk("rst_IRWrite", bus.IRWrite, 1'b0);
    chk("rst_PCWrite", bus.PCWrite, 1'b0);
    chk("rst_instret", bus.instret, 4'd0);
    chk("rst_trap", bus.trap, 1'b0);
    chk("rst_bus_err", bus.bus_err, 1'b0);
    do_reset();

    // Zero-wait program.
    run_instr(OP_LW, 1'b0, 0, 0, tr, ncyc);
    chk("lw_trace", tr, 32'h01234);
    chk("lw_cycles", ncyc, 5);
    run_instr(OP_SW, 1'b0, 0, 0, tr, ncyc);
    chk("sw_trace", tr, 32'h0125);
    chk("sw_cycles", ncyc, 4);
    run_instr(OP_R, 1'b0, 0, 0, tr, ncyc);
    chk("r_trace", tr, 32'h0168);
    beq_pcw = 1'b0;
    run_instr(OP_BEQ, 1'b1, 0, 0, tr, ncyc);
    chk("beq_trace", tr, 32'h019);
    chk("beq_cycles", ncyc, 3);
    chk("beq_taken_pcw", beq_pcw, 1'b1);
    run_instr(OP_I, 1'b0, 0, 0, tr, ncyc);
    chk("i_trace", tr, 32'h0178);
    run_instr(OP_JAL, 1'b0, 0, 0, tr, ncyc);
    chk("jal_trace", tr, 32'h01A8);
    chk("seq_instret", bus.instret, 4'd6);

    beq_pcw = 1'b1;
    run_instr(OP_BEQ, 1'b0, 0, 0, tr, ncyc);
    chk("beq_nottaken_pcw", beq_pcw, 1'b0);
    chk("beq_instret", bus.instret, 4'd7);

    // Slow instruction fetch.
    fetch_cyc = 0;
    irw_cnt   = 0;
    irw_at    = 0;
    run_instr(OP_R, 1'b0, 3, 0, tr, ncyc);
    chk("fetch_hold", fetch_cyc, 4);
    chk("fetch_irw_cnt", irw_cnt, 1);
    chk("fetch_irw_at", irw_at, 4);
    chk("fetch_cycles", ncyc, 7);

    // Load with two data wait cycles.
    run_instr(OP_LW, 1'b0, 0, 2, tr, ncyc);
    chk("lw_wait_cycles", ncyc, 7);
    chk("lw_wait_instret", bus.instret, 4'd9);

    // Load whose data never arrives.
    berr_cnt = 0;
    run_instr(OP_LW, 1'b0, 0, 100, tr, ncyc);
    chk("to_trace", tr, 32'h0123);
    chk("to_cycles", ncyc, 8);
    chk("to_pulses", berr_cnt, 1);
    chk("to_delay", berr_cyc - rd_entry, 4);
    chk("to_instret", bus.instret, 4'd9);

    // Illegal opcode.
    run_instr(OP_BAD, 1'b0, 0, 0, tr, ncyc);
    chk("bad_trace", tr, 32'h01);
`ifdef ILLEGAL_OP_TRAP_EN
    repeat (3) @(posedge clk);
    #1;
    chk("bad_trap_state", bus.state, 4'd11);
    chk("bad_trap_flag", bus.trap, 1'b1);
    chk("bad_trap_mem_req", bus.mem_req, 1'b0);
`else
    chk("bad_cycles", ncyc, 2);
    chk("bad_trap_flag", bus.trap, 1'b0);
`endif
    chk("bad_instret", bus.instret, 4'd9);

    // Asynchronous reset in the middle of a store.
    do_reset();
    run_instr(OP_R, 1'b0, 0, 0, tr, ncyc);
    chk("pre_rst_instret", bus.instret, 4'd1);
    bus.Op        = OP_SW;
    bus.mem_ready = 1'b1;
    ncyc          = 0;
    while (bus.state != 4'd5 && ncyc < 10) begin
      @(posedge clk);
      #1;
      ncyc++;
    end
    bus.mem_ready = 1'b0;
    chk("ar_reach_memwrite", bus.state, 4'd5);
    #2;
    chk("ar_memwrite_before", bus.MemWrite, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("ar_memwrite_after", bus.MemWrite, 1'b0);
    chk("ar_state_after", bus.state, 4'd0);
    chk("ar_instret_after", bus.instret, 4'd0);
    $display("async reset during store: state=%0d MemWrite=%0b", bus.state, bus.MemWrite);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Counter wrap at CNT_W=4.
    for (int i = 1; i <= 16; i++) begin
      run_instr(OP_I, 1'b0, 0, 0, tr, ncyc);
      if (i == 15) chk("wrap_15", bus.instret, 4'd15);
      if (i == 16) chk("wrap_16", bus.instret, 4'd0);
    end

    @(negedge clk);
    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

endmodule
